ser_frame_tx: RTL and testbench

Serial frame transmitter that sits directly upstream of the serial demultiplexer system. It accepts a parallel request (destination port, data length, data word) and shifts it out on one serial line as start bit, port address, length and payload. `ser_out` connects to the demultiplexer's `ser_in`. Bit advance is gated by the same one-pulser clock enable, so both ends step together.

---
 rtl/ser_frame_tx_pkg.sv | 24 ++
 rtl/ser_frame_tx_bit_counter.sv | 40 ++++
 rtl/ser_frame_tx.sv | 203 ++++++++++++++++++++
 tb/tb_ser_frame_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ser_frame_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ser_frame_tx_pkg
// Purpose  : Shared definitions for the serial frame transmitter and the
//            downstream demultiplexer datapath: FSM state encoding, port
//            address width and default field widths.
// Revision : 1.0 - initial release
// ============================================================================
package ser_frame_tx_pkg;

    localparam int PORT_W     = 2;   // destination port address width
    localparam int LEN_W_DEF  = 4;   // default length field width
    localparam int DATA_W_DEF = 15;  // default payload register width

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_PORT  = 3'd2,
        ST_LEN   = 3'd3,
        ST_DATA  = 3'd4
    } state_t;

endpackage : ser_frame_tx_pkg
`default_nettype wire

// File: rtl/ser_frame_tx_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : frame_bit_counter
// Purpose  : Loadable down-counter that tracks the remaining bits of the
//            current frame field. It saturates at zero instead of wrapping.
// Ports    : clk        - system clock
//            rst        - asynchronous active-high reset
//            i_en       - decrement enable (bit consumed)
//            i_load     - load i_load_val (takes priority over i_en)
//            i_load_val - reload value (bits in field minus one)
//            o_tc       - terminal count, high when the count is zero
// Revision : 1.0 - initial release
// ============================================================================
module frame_bit_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_tc = (r_count == '0);

endmodule : frame_bit_counter
`default_nettype wire

// File: rtl/ser_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : ser_frame_tx
// Purpose  : Serial frame transmitter. Captures a parallel request and shifts
//            out start bit (0), port address (MSB first), length (MSB first)
//            and N payload bits (LSB first), one bit per clk_en strobe.
// Ports    : clk      - system clock
//            rst      - asynchronous active-high reset
//            clk_en   - bit-advance strobe
//            start    - request strobe, accepted only while idle
//            port_sel - destination port
//            len      - payload bit count (clamped to DATA_W)
//            data     - payload word
//            ser_out  - registered serial line, idle high
//            busy     - high from accept until frame end
//            done     - one-cycle pulse at frame end
// Revision : 1.0 - initial release
// ============================================================================
module ser_frame_tx
    import ser_frame_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic                start,
    input  logic [PORT_W-1:0]   port_sel,
    input  logic [LEN_W-1:0]    len,
    input  logic [DATA_W-1:0]   data,
    output logic                ser_out,
    output logic                busy,
    output logic                done
);

    // The length field can always hold DATA_W, so LEN_W bits suffice for
    // every reload value (1, LEN_W-1, N-1).
    localparam int               CNT_W        = LEN_W;
    localparam logic [LEN_W-1:0] c_data_w_len = LEN_W'(DATA_W);

    state_t              r_state, w_state_nxt;
    logic                r_ser_out, w_ser_nxt;
    logic                r_busy, w_busy_nxt;
    logic                r_done, w_done_nxt;
    logic [PORT_W-1:0]   r_port_sh, w_port_sh_nxt;
    logic [LEN_W-1:0]    r_len_sh, w_len_sh_nxt;
    logic [LEN_W-1:0]    r_len_n, w_len_n_nxt;
    logic [DATA_W-1:0]   r_data_sh, w_data_sh_nxt;

    logic                w_len_clamp_sel;
    logic [LEN_W-1:0]    w_len_clamp;
    logic                w_cnt_load;
    logic                w_cnt_dec;
    logic [CNT_W-1:0]    w_cnt_val;
    logic                w_cnt_tc;

    assign w_len_clamp_sel = (len > c_data_w_len);
    assign w_len_clamp     = w_len_clamp_sel ? c_data_w_len : len;

    frame_bit_counter #(
        .CNT_W (CNT_W)
    ) u_bit_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_cnt_dec),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .o_tc       (w_cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Each shift register is shifted as its bit is moved onto ser_out, so the
    // next bit of a field is always at the MSB (port/len) or LSB (data).
    always_comb begin
        w_state_nxt   = r_state;
        w_ser_nxt     = r_ser_out;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_port_sh_nxt = r_port_sh;
        w_len_sh_nxt  = r_len_sh;
        w_len_n_nxt   = r_len_n;
        w_data_sh_nxt = r_data_sh;
        w_cnt_load    = 1'b0;
        w_cnt_dec     = 1'b0;
        w_cnt_val     = '0;

        case (r_state)
            ST_IDLE: begin
                w_ser_nxt  = 1'b1;
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_port_sh_nxt = port_sel;
                    w_len_sh_nxt  = w_len_clamp;
                    w_len_n_nxt   = w_len_clamp;
                    w_data_sh_nxt = data;
                    w_ser_nxt     = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = ST_START;
                end
            end
            ST_START: begin
                if (clk_en) begin
                    w_ser_nxt     = r_port_sh[PORT_W-1];
                    w_port_sh_nxt = r_port_sh << 1;
                    w_cnt_load    = 1'b1;
                    w_cnt_val     = CNT_W'(PORT_W - 1);
                    w_state_nxt   = ST_PORT;
                end
            end
            ST_PORT: begin
                if (clk_en) begin
                    if (w_cnt_tc) begin
                        w_ser_nxt    = r_len_sh[LEN_W-1];
                        w_len_sh_nxt = r_len_sh << 1;
                        w_cnt_load   = 1'b1;
                        w_cnt_val    = CNT_W'(LEN_W - 1);
                        w_state_nxt  = ST_LEN;
                    end else begin
                        w_ser_nxt     = r_port_sh[PORT_W-1];
                        w_port_sh_nxt = r_port_sh << 1;
                        w_cnt_dec     = 1'b1;
                    end
                end
            end
            ST_LEN: begin
                if (clk_en) begin
                    if (w_cnt_tc) begin
                        if (r_len_n == '0) begin
                            // Empty payload: frame ends after the length field.
                            w_ser_nxt   = 1'b1;
                            w_busy_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_ser_nxt     = r_data_sh[0];
                            w_data_sh_nxt = r_data_sh >> 1;
                            w_cnt_load    = 1'b1;
                            w_cnt_val     = r_len_n - 1'b1;
                            w_state_nxt   = ST_DATA;
                        end
                    end else begin
                        w_ser_nxt    = r_len_sh[LEN_W-1];
                        w_len_sh_nxt = r_len_sh << 1;
                        w_cnt_dec    = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (clk_en) begin
                    if (w_cnt_tc) begin
                        w_ser_nxt   = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ser_nxt     = r_data_sh[0];
                        w_data_sh_nxt = r_data_sh >> 1;
                        w_cnt_dec     = 1'b1;
                    end
                end
            end
            default: begin
                w_ser_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ser_out <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_port_sh <= '0;
            r_len_sh  <= '0;
            r_len_n   <= '0;
            r_data_sh <= '0;
        end else begin
            r_ser_out <= w_ser_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_port_sh <= w_port_sh_nxt;
            r_len_sh  <= w_len_sh_nxt;
            r_len_n   <= w_len_n_nxt;
            r_data_sh <= w_data_sh_nxt;
        end
    end

    assign ser_out = r_ser_out;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule : ser_frame_tx
`default_nettype wire

// File: tb/tb_ser_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ser_frame_tx
// Purpose  : Self-checking bench for ser_frame_tx. Two instances: the default
//            widths (DATA_W=15) and a narrow payload (DATA_W=12) so that
//            length clamping is exercised. Expected frames are built from the
//            frame format and queued; a monitor consumes them bit by bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ser_frame_tx;

    localparam int LW  = 4;
    localparam int DW0 = 15;
    localparam int DW1 = 12;
    localparam int TMO = 2000;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        start_v [2];
    logic [1:0]  port_v  [2];
    logic [3:0]  len_v   [2];
    logic [14:0] data_v  [2];
    logic        ser_v   [2];
    logic        busy_v  [2];
    logic        done_v  [2];

    int checks = 0;
    int errors = 0;
    int ce_mode = 4;   // 0: random strobe, N>0: strobe every N-th cycle
    int ce_cnt  = 0;

    bit exp_bits [2][$];
    int exp_len  [2][$];
    int bits_left [2];
    bit exp_done  [2];

    ser_frame_tx #(.DATA_W(DW0), .LEN_W(LW)) dut0 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start_v[0]),
        .port_sel(port_v[0]), .len(len_v[0]), .data(data_v[0]),
        .ser_out(ser_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    ser_frame_tx #(.DATA_W(DW1), .LEN_W(LW)) dut1 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start_v[1]),
        .port_sel(port_v[1]), .len(len_v[1]), .data(data_v[1][11:0]),
        .ser_out(ser_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference frame: 0, port MSB first, clamped length MSB first, payload LSB first.
    function automatic void build_frame(input int d, input logic [1:0] p,
                                        input int n_req, input logic [14:0] dat);
        int dw;
        int n;
        dw = (d == 0) ? DW0 : DW1;
        n  = (n_req > dw) ? dw : n_req;
        exp_bits[d].push_back(1'b0);
        for (int i = 1; i >= 0; i--) exp_bits[d].push_back(p[i]);
        for (int i = LW - 1; i >= 0; i--) exp_bits[d].push_back(((n >> i) & 1) != 0);
        for (int i = 0; i < n; i++) exp_bits[d].push_back(dat[i]);
        exp_len[d].push_back(3 + LW + n);
    endfunction

    // Bit-advance strobe generator.
    initial begin
        clk_en = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (ce_mode == 0) begin
                clk_en = ($urandom_range(0, 1) == 1);
            end else begin
                ce_cnt = (ce_cnt + 1 >= ce_mode) ? 0 : ce_cnt + 1;
                clk_en = (ce_cnt == 0);
            end
        end
    end

    // Monitor: a bit is consumed when busy and clk_en are both high ahead of
    // the next rising edge.
    initial begin
        for (int d = 0; d < 2; d++) begin
            bits_left[d] = 0;
            exp_done[d]  = 1'b0;
        end
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    bits_left[d] = 0;
                    exp_done[d]  = 1'b0;
                    exp_bits[d].delete();
                    exp_len[d].delete();
                end else begin
                    if (exp_done[d]) begin
                        chk($sformatf("done_pulse[%0d]", d), 32'(done_v[d]), 32'd1);
                        chk($sformatf("busy_end[%0d]", d), 32'(busy_v[d]), 32'd0);
                        chk($sformatf("ser_end[%0d]", d), 32'(ser_v[d]), 32'd1);
                        exp_done[d] = 1'b0;
                    end else begin
                        chk($sformatf("no_done[%0d]", d), 32'(done_v[d]), 32'd0);
                    end
                    if (bits_left[d] > 0)
                        chk($sformatf("busy_frame[%0d]", d), 32'(busy_v[d]), 32'd1);
                    if (!busy_v[d])
                        chk($sformatf("ser_idle[%0d]", d), 32'(ser_v[d]), 32'd1);
                    if (busy_v[d] && clk_en) begin
                        if (bits_left[d] == 0) begin
                            if (exp_len[d].size() == 0) begin
                                chk($sformatf("unexpected_frame[%0d]", d), 32'd1, 32'd0);
                                bits_left[d] = -1;
                            end else begin
                                bits_left[d] = exp_len[d].pop_front();
                            end
                        end
                        if (bits_left[d] > 0) begin
                            chk($sformatf("ser_bit[%0d]", d), 32'(ser_v[d]),
                                32'(exp_bits[d].pop_front()));
                            bits_left[d]--;
                            if (bits_left[d] == 0) exp_done[d] = 1'b1;
                        end else begin
                            bits_left[d] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (busy_v[d] && n < TMO) begin
            cycles(1);
            n++;
        end
        chk($sformatf("idle_timeout[%0d]", d), 32'(busy_v[d]), 32'd0);
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        while (!done_v[d] && n < TMO) begin
            cycles(1);
            n++;
        end
        chk($sformatf("done_timeout[%0d]", d), 32'(done_v[d]), 32'd1);
    endtask

    // Issue an accepted request and check the accept latency.
    task automatic send(input int d, input logic [1:0] p, input int n, input logic [14:0] dat);
        wait_idle(d);
        port_v[d]  = p;
        len_v[d]   = 4'(n);
        data_v[d]  = dat;
        start_v[d] = 1'b1;
        build_frame(d, p, n, dat);
        cycles(1);
        start_v[d] = 1'b0;
        chk($sformatf("accept_busy[%0d]", d), 32'(busy_v[d]), 32'd1);
        chk($sformatf("accept_ser[%0d]", d), 32'(ser_v[d]), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_v[d] = 1'b0;
            port_v[d]  = '0;
            len_v[d]   = '0;
            data_v[d]  = '0;
        end
        cycles(3);
        rst = 1'b0;
        cycles(5);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_ser[%0d]", d), 32'(ser_v[d]), 32'd1);
            chk($sformatf("reset_busy[%0d]", d), 32'(busy_v[d]), 32'd0);
            chk($sformatf("reset_done[%0d]", d), 32'(done_v[d]), 32'd0);
        end

        // Directed frames with a strobe every 4th cycle.
        ce_mode = 4;
        send(0, 2'b10, 3, 15'b101);
        send(0, 2'b11, 0, 15'h7FFF);
        send(0, 2'b01, 15, 15'h5A5A);
        send(1, 2'b10, 15, 15'h3A5C);
        wait_idle(0);
        wait_idle(1);

        // Start while busy must be ignored.
        send(0, 2'b00, 9, 15'h1234);
        cycles(10);
        port_v[0] = 2'b11; len_v[0] = 4'd2; data_v[0] = 15'h0003;
        start_v[0] = 1'b1;
        cycles(2);
        start_v[0] = 1'b0;

        // Start in the done cycle begins the next frame immediately.
        wait_done(0);
        send(0, 2'b10, 4, 15'h000B);
        wait_idle(0);

        // Reset mid-frame abandons the frame with no done pulse.
        send(0, 2'b11, 10, 15'h2AAA);
        cycles(15);
        rst = 1'b1;
        #1;
        chk("midrst_ser", 32'(ser_v[0]), 32'd1);
        chk("midrst_busy", 32'(busy_v[0]), 32'd0);
        chk("midrst_done", 32'(done_v[0]), 32'd0);
        cycles(2);
        rst = 1'b0;
        cycles(20);

        // Randomized frames on both widths with varying strobe patterns.
        repeat (40) begin
            int d;
            d = $urandom_range(0, 1);
            ce_mode = $urandom_range(0, 3);
            send(d, 2'($urandom_range(0, 3)), $urandom_range(0, 15), 15'($urandom));
            if ($urandom_range(0, 3) == 0) wait_done(d);
        end
        wait_idle(0);
        wait_idle(1);
        cycles(4);
        for (int d = 0; d < 2; d++)
            chk($sformatf("queue_empty[%0d]", d), 32'(exp_len[d].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ser_frame_tx
`default_nettype wire
